pwm_update_ctrl: RTL and testbench

- Configuration sequencer in front of `pwm_timebase`. Accepts period, duty and enable updates over a valid/ready handshake.
- Holds each update in shadow registers and commits it atomically at a period boundary (`tb_period_end`), so the PWM output never glitches mid-period.
- Drives `tb_enable` and `tb_period_cycles` into the timebase, and `duty_cycles` to the compare stage.

---
 rtl/pwm_pkg.sv | 28 ++
 rtl/pwm_update_ctrl.sv | 143 ++++++++++++++
 tb/tb_pwm_update_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM configuration path (update controller and timebase).
package pwm_pkg;

  localparam int PWM_CNT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PENDING = 2'd2
  } pwm_upd_state_t;

  typedef struct packed {
    logic                     enable;
    logic [PWM_CNT_WIDTH-1:0] period;
    logic [PWM_CNT_WIDTH-1:0] duty;
  } pwm_cfg_t;

  // Period actually run by the timebase: 0 selects the default, 1 is widened to 2.
  function automatic logic [PWM_CNT_WIDTH-1:0] eff_period(
    input logic [PWM_CNT_WIDTH-1:0] period,
    input logic [PWM_CNT_WIDTH-1:0] dflt
  );
    if (period == '0) return dflt;
    else if (period == PWM_CNT_WIDTH'(1)) return PWM_CNT_WIDTH'(2);
    else return period;
  endfunction

endpackage

// File: rtl/pwm_update_ctrl.sv
// Shadowed PWM configuration sequencer: commits enable/period/duty atomically at a period end.
// Optional forced-commit timeout when PWM_UPD_TIMEOUT_EN is defined (adds port update_timeout).
module pwm_update_ctrl
  import pwm_pkg::*;
#(
  parameter int CNT_WIDTH             = PWM_CNT_WIDTH,
  parameter int DEFAULT_PERIOD_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES        = 1_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // cfg handshake: a transfer happens on a posedge where cfg_valid && cfg_ready.
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic                 cfg_enable,
  input  logic [CNT_WIDTH-1:0] cfg_period,
  input  logic [CNT_WIDTH-1:0] cfg_duty,
  input  logic                 tb_period_end,
  output logic                 tb_enable,
  output logic [CNT_WIDTH-1:0] tb_period_cycles,
  output logic [CNT_WIDTH-1:0] duty_cycles,
  output logic                 update_pending,
  output logic                 update_done,
`ifdef PWM_UPD_TIMEOUT_EN
  output logic                 update_timeout,
`endif
  output logic [1:0]           dbg_state
);

  pwm_upd_state_t       state_q, state_d;
  pwm_cfg_t             shadow_q, shadow_d;
  pwm_cfg_t             cfg_in, commit_src;
  logic                 tb_enable_q, tb_enable_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] duty_q, duty_d;
  logic                 done_q, done_d;
  logic [CNT_WIDTH-1:0] p_eff;
  logic                 commit;
  logic                 xfer;
`ifdef PWM_UPD_TIMEOUT_EN
  logic [CNT_WIDTH-1:0] tmo_cnt_q, tmo_cnt_d;
  logic                 tmo_q, tmo_d;
`endif

  assign cfg_ready = (state_q != PENDING);
  assign xfer      = cfg_valid && cfg_ready;
  assign cfg_in    = '{enable: cfg_enable, period: cfg_period, duty: cfg_duty};

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    tb_enable_d = tb_enable_q;
    period_d    = period_q;
    duty_d      = duty_q;
    done_d      = 1'b0;
    commit      = 1'b0;
    commit_src  = cfg_in;
    p_eff       = '0;
`ifdef PWM_UPD_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    tmo_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (xfer) commit = 1'b1;
      end
      RUN: begin
        if (xfer) begin
          if (tb_period_end) begin
            commit = 1'b1;
          end else begin
            shadow_d = cfg_in;
            state_d  = PENDING;
`ifdef PWM_UPD_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
          end
        end
      end
      PENDING: begin
        commit_src = shadow_q;
        if (tb_period_end) begin
          commit = 1'b1;
`ifdef PWM_UPD_TIMEOUT_EN
        end else if (tmo_cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
          commit = 1'b1;
          tmo_d  = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    // Every commit path lands here so the three outputs always move together.
    if (commit) begin
      p_eff       = eff_period(commit_src.period, CNT_WIDTH'(DEFAULT_PERIOD_CYCLES));
      tb_enable_d = commit_src.enable;
      period_d    = commit_src.period;
      duty_d      = (commit_src.duty > p_eff) ? p_eff : commit_src.duty;
      done_d      = 1'b1;
      state_d     = commit_src.enable ? RUN : IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      tb_enable_q <= 1'b0;
      period_q    <= '0;
      duty_q      <= '0;
      done_q      <= 1'b0;
`ifdef PWM_UPD_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      tmo_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      tb_enable_q <= tb_enable_d;
      period_q    <= period_d;
      duty_q      <= duty_d;
      done_q      <= done_d;
`ifdef PWM_UPD_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign tb_enable        = tb_enable_q;
  assign tb_period_cycles = period_q;
  assign duty_cycles      = duty_q;
  assign update_pending   = (state_q == PENDING);
  assign update_done      = done_q;
  assign dbg_state        = state_q;
`ifdef PWM_UPD_TIMEOUT_EN
  assign update_timeout   = tmo_q;
`endif

endmodule

// File: tb/tb_pwm_update_ctrl.sv
// Directed bench for pwm_update_ctrl: vector table plus hand sequences for reset and timeout.
module tb_pwm_update_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        cfg_enable;
  logic [31:0] cfg_period;
  logic [31:0] cfg_duty;
  logic        tb_period_end;
  logic        tb_enable;
  logic [31:0] tb_period_cycles;
  logic [31:0] duty_cycles;
  logic        update_pending;
  logic        update_done;
  logic [1:0]  dbg_state;
`ifdef PWM_UPD_TIMEOUT_EN
  logic        update_timeout;
`endif

  int n_cmp;
  int n_err;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PEND = 2'd2;

  pwm_update_ctrl #(
    .CNT_WIDTH(32),
    .DEFAULT_PERIOD_CYCLES(5000),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_enable(cfg_enable),
    .cfg_period(cfg_period),
    .cfg_duty(cfg_duty),
    .tb_period_end(tb_period_end),
    .tb_enable(tb_enable),
    .tb_period_cycles(tb_period_cycles),
    .duty_cycles(duty_cycles),
    .update_pending(update_pending),
    .update_done(update_done),
`ifdef PWM_UPD_TIMEOUT_EN
    .update_timeout(update_timeout),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        e;
    logic [31:0] p;
    logic [31:0] d;
    logic        pe;
    logic        x_en;
    logic [31:0] x_per;
    logic [31:0] x_duty;
    logic        x_pend;
    logic        x_done;
    logic        x_rdy;
    logic [1:0]  x_st;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(
    input logic v, input logic e, input logic [31:0] p, input logic [31:0] d, input logic pe,
    input logic x_en, input logic [31:0] x_per, input logic [31:0] x_duty,
    input logic x_pend, input logic x_done, input logic x_rdy, input logic [1:0] x_st
  );
    vec_t r;
    r.v = v; r.e = e; r.p = p; r.d = d; r.pe = pe;
    r.x_en = x_en; r.x_per = x_per; r.x_duty = x_duty;
    r.x_pend = x_pend; r.x_done = x_done; r.x_rdy = x_rdy; r.x_st = x_st;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic en, input logic [31:0] per,
                         input logic [31:0] duty, input logic pend, input logic done,
                         input logic rdy, input logic [1:0] st);
    chk({tag, ".tb_enable"}, 32'(tb_enable), 32'(en));
    chk({tag, ".tb_period_cycles"}, tb_period_cycles, per);
    chk({tag, ".duty_cycles"}, duty_cycles, duty);
    chk({tag, ".update_pending"}, 32'(update_pending), 32'(pend));
    chk({tag, ".update_done"}, 32'(update_done), 32'(done));
    chk({tag, ".cfg_ready"}, 32'(cfg_ready), 32'(rdy));
    chk({tag, ".state"}, 32'(dbg_state), 32'(st));
  endtask

  // driver: set inputs, then sample #1 after the next rising edge
  task automatic drive(input logic v, input logic e, input logic [31:0] p,
                       input logic [31:0] d, input logic pe);
    cfg_valid = v; cfg_enable = e; cfg_period = p; cfg_duty = d; tb_period_end = pe;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    cfg_valid = 1'b0; cfg_enable = 1'b0; cfg_period = '0; cfg_duty = '0; tb_period_end = 1'b0;
    rst_n = 1'b0;

    //               v  e  per   duty  pe | en per  duty pend done rdy state
    vecs[0]  = mk(0, 0, 0,  0,    0,   0, 0,  0,    0, 0, 1, S_IDLE);
    vecs[1]  = mk(0, 0, 0,  0,    0,   0, 0,  0,    0, 0, 1, S_IDLE);
    vecs[2]  = mk(1, 1, 10, 4,    0,   1, 10, 4,    0, 1, 1, S_RUN);
    vecs[3]  = mk(0, 0, 0,  0,    0,   1, 10, 4,    0, 0, 1, S_RUN);
    vecs[4]  = mk(1, 1, 20, 8,    0,   1, 10, 4,    1, 0, 0, S_PEND);
    vecs[5]  = mk(0, 0, 0,  0,    0,   1, 10, 4,    1, 0, 0, S_PEND);
    vecs[6]  = mk(1, 1, 30, 3,    1,   1, 20, 8,    0, 1, 1, S_RUN);
    vecs[7]  = mk(1, 1, 30, 3,    0,   1, 20, 8,    1, 0, 0, S_PEND);
    vecs[8]  = mk(0, 0, 0,  0,    1,   1, 30, 3,    0, 1, 1, S_RUN);
    vecs[9]  = mk(1, 1, 0,  6000, 1,   1, 0,  5000, 0, 1, 1, S_RUN);
    vecs[10] = mk(1, 1, 1,  5,    1,   1, 1,  2,    0, 1, 1, S_RUN);
    vecs[11] = mk(1, 1, 7,  9,    0,   1, 1,  2,    1, 0, 0, S_PEND);
    vecs[12] = mk(0, 0, 0,  0,    1,   1, 7,  7,    0, 1, 1, S_RUN);
    vecs[13] = mk(1, 0, 10, 4,    0,   1, 7,  7,    1, 0, 0, S_PEND);
    vecs[14] = mk(0, 0, 0,  0,    0,   1, 7,  7,    1, 0, 0, S_PEND);
    vecs[15] = mk(1, 1, 12, 5,    1,   0, 10, 4,    0, 1, 1, S_IDLE);
    vecs[16] = mk(1, 1, 12, 5,    0,   1, 12, 5,    0, 1, 1, S_RUN);
    vecs[17] = mk(0, 0, 0,  0,    1,   1, 12, 5,    0, 0, 1, S_RUN);
    vecs[18] = mk(1, 0, 3,  2,    1,   0, 3,  2,    0, 1, 1, S_IDLE);
    vecs[19] = mk(0, 0, 0,  0,    1,   0, 3,  2,    0, 0, 1, S_IDLE);
    vecs[20] = mk(1, 0, 9,  99,   0,   0, 9,  9,    0, 1, 1, S_IDLE);

    // reset state while held
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 1, S_IDLE);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].v, vecs[i].e, vecs[i].p, vecs[i].d, vecs[i].pe);
      chk_all($sformatf("vec%0d", i), vecs[i].x_en, vecs[i].x_per, vecs[i].x_duty,
              vecs[i].x_pend, vecs[i].x_done, vecs[i].x_rdy, vecs[i].x_st);
    end

    // reset while PENDING: async clear, shadow dropped
    drive(1, 1, 10, 4, 0);
    drive(1, 1, 20, 8, 0);
    chk_all("pre_rst", 1, 10, 4, 1, 0, 0, S_PEND);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0, 1, S_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    chk_all("post_rst", 0, 0, 0, 0, 0, 1, S_IDLE);
    drive(0, 0, 0, 0, 1);
    chk_all("post_rst_pe", 0, 0, 0, 0, 0, 1, S_IDLE);

    // stalled timebase while PENDING
    drive(1, 1, 10, 4, 0);
    drive(1, 1, 40, 50, 0);
    chk_all("stall_entry", 1, 10, 4, 1, 0, 0, S_PEND);
    for (int k = 0; k < 15; k++) drive(0, 0, 0, 0, 0);
    chk_all("stall_15", 1, 10, 4, 1, 0, 0, S_PEND);
    drive(0, 0, 0, 0, 0);
`ifdef PWM_UPD_TIMEOUT_EN
    chk_all("stall_16", 1, 40, 40, 0, 1, 1, S_RUN);
    chk("update_timeout_pulse", 32'(update_timeout), 32'd1);
    drive(0, 0, 0, 0, 0);
    chk("update_timeout_clear", 32'(update_timeout), 32'd0);
`else
    chk_all("stall_16", 1, 10, 4, 1, 0, 0, S_PEND);
    repeat (20) drive(0, 0, 0, 0, 0);
    chk_all("stall_36", 1, 10, 4, 1, 0, 0, S_PEND);
    drive(0, 0, 0, 0, 1);
    chk_all("stall_release", 1, 40, 40, 0, 1, 1, S_RUN);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
